// File: rtl/counter_updown_param_pkg.sv
// Shared mode encoding and helpers for the up/down/skip/load counter.
package counter_updown_param_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DN   = 2'b01,
        MODE_SKIP = 2'b10,
        MODE_LD   = 2'b11
    } mode_e;

    // Counting modes are everything except load; only they honour cin and flag boundaries.
    function automatic logic is_count_mode(input logic [1:0] m);
        return m != MODE_LD;
    endfunction

endpackage

// File: rtl/counter_step_alu.sv
// Combinational next-value and boundary detection for the counting modes.
module counter_step_alu
    import counter_updown_param_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int STEP     = 3,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] Q,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_q,
    output logic             at_bnd
);

    localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic [WIDTH:0] q_x;
    logic [WIDTH:0] res_x;

    assign q_x = {1'b0, Q};

    // One extra bit carries the carry/borrow: it is set exactly when the step
    // crosses all-ones (up) or goes below zero (down, skip with Q < STEP).
    always_comb begin
        res_x  = q_x;
        at_bnd = 1'b0;
        case (mode_e'(mode))
            MODE_UP:   res_x = q_x + ONE_X;
            MODE_DN:   res_x = q_x - ONE_X;
            MODE_SKIP: res_x = q_x - STEP_X;
            default:   res_x = q_x;
        endcase
        if (is_count_mode(mode))
            at_bnd = res_x[WIDTH];
        next_q = res_x[WIDTH-1:0];
        if (at_bnd && (SATURATE != 0))
            next_q = (mode_e'(mode) == MODE_UP) ? '1 : '0;
    end

endmodule

// File: rtl/counter_updown_param.sv
// Parametrised up/down/skip/load counter with wrap-or-saturate, cascade input
// and combinational terminal count for chaining.
module counter_updown_param
    import counter_updown_param_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int STEP     = 3,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cin,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             load,
    output logic             tc
);

    logic [WIDTH-1:0] next_q;
    logic             at_bnd;

    counter_step_alu #(
        .WIDTH    (WIDTH),
        .STEP     (STEP),
        .SATURATE (SATURATE)
    ) u_alu (
        .Q      (Q),
        .mode   (mode),
        .next_q (next_q),
        .at_bnd (at_bnd)
    );

    // Terminal count is the look-ahead of rco; the next stage's cin is driven from it.
    assign tc = enable & cin & is_count_mode(mode) & at_bnd;

    // Count register and one-cycle flags; flags clear every edge unless reasserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            Q    <= '0;
            rco  <= 1'b0;
            load <= 1'b0;
        end else begin
            rco  <= 1'b0;
            load <= 1'b0;
            if (enable) begin
                if (!is_count_mode(mode)) begin
                    Q    <= D;
                    load <= 1'b1;
                end else if (cin) begin
                    Q   <= next_q;
                    rco <= at_bnd;
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_updown_param.sv
// Directed test of the counter: wrap and saturate variants, cascade, 32-bit smoke.
module tb_counter_updown_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Wrap and saturate instances share one set of stimulus.
    logic       a_rst, a_en, a_cin;
    logic [1:0] a_mode;
    logic [3:0] a_d;
    logic [3:0] a_q, s_q;
    logic       a_rco, a_load, a_tc, s_rco, s_load, s_tc;

    counter_updown_param #(.WIDTH(4), .STEP(3), .SATURATE(0)) u_a (
        .clk(clk), .reset(a_rst), .enable(a_en), .cin(a_cin), .mode(a_mode), .D(a_d),
        .Q(a_q), .rco(a_rco), .load(a_load), .tc(a_tc));

    counter_updown_param #(.WIDTH(4), .STEP(3), .SATURATE(1)) u_s (
        .clk(clk), .reset(a_rst), .enable(a_en), .cin(a_cin), .mode(a_mode), .D(a_d),
        .Q(s_q), .rco(s_rco), .load(s_load), .tc(s_tc));

    // Two-stage cascade.
    logic       c_rst;
    logic [3:0] lo_q, hi_q;
    logic       lo_rco, lo_load, lo_tc, hi_rco, hi_load, hi_tc;

    counter_updown_param #(.WIDTH(4), .STEP(3), .SATURATE(0)) u_lo (
        .clk(clk), .reset(c_rst), .enable(1'b1), .cin(1'b1), .mode(2'b00), .D(4'h0),
        .Q(lo_q), .rco(lo_rco), .load(lo_load), .tc(lo_tc));

    counter_updown_param #(.WIDTH(4), .STEP(3), .SATURATE(0)) u_hi (
        .clk(clk), .reset(c_rst), .enable(1'b1), .cin(lo_tc), .mode(2'b00), .D(4'h0),
        .Q(hi_q), .rco(hi_rco), .load(hi_load), .tc(hi_tc));

    // 32-bit instance.
    logic        w_rst;
    logic [1:0]  w_mode;
    logic [31:0] w_d, w_q;
    logic        w_rco, w_load, w_tc;

    counter_updown_param #(.WIDTH(32), .STEP(3), .SATURATE(0)) u_w (
        .clk(clk), .reset(w_rst), .enable(1'b1), .cin(1'b1), .mode(w_mode), .D(w_d),
        .Q(w_q), .rco(w_rco), .load(w_load), .tc(w_tc));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        a_rst = 1'b1; a_en = 1'b1; a_cin = 1'b1; a_mode = 2'b00; a_d = 4'h0;
        c_rst = 1'b1;
        w_rst = 1'b1; w_mode = 2'b00; w_d = 32'h0;

        // 1. reset for two edges, then count up
        tick(); tick();
        check("rst_q", 32'(a_q), 32'h0);
        check("rst_rco", 32'(a_rco), 32'h0);
        check("rst_load", 32'(a_load), 32'h0);
        check("rst_tc", 32'(a_tc), 32'h0);
        check("rst_sq", 32'(s_q), 32'h0);
        a_rst = 1'b0;
        tick(); check("up_q1", 32'(a_q), 32'h1);
        tick(); check("up_q2", 32'(a_q), 32'h2);
        tick(); check("up_q3", 32'(a_q), 32'h3);

        // 2. load E then count up through the wrap
        a_mode = 2'b11; a_d = 4'hE;
        tick();
        check("ld_q", 32'(a_q), 32'hE);
        check("ld_load", 32'(a_load), 32'h1);
        check("ld_rco", 32'(a_rco), 32'h0);
        a_mode = 2'b00; #1;
        check("tc_at_E", 32'(a_tc), 32'h0);
        tick();
        check("up_qF", 32'(a_q), 32'hF);
        check("up_load_clr", 32'(a_load), 32'h0);
        check("up_rcoF", 32'(a_rco), 32'h0);
        check("tc_at_F", 32'(a_tc), 32'h1);
        tick();
        check("wrap_q0", 32'(a_q), 32'h0);
        check("wrap_rco", 32'(a_rco), 32'h1);
        check("tc_at_0", 32'(a_tc), 32'h0);

        // 3. skip-down by 3 from 4, wrap vs saturate
        a_mode = 2'b11; a_d = 4'h4;
        tick();
        a_mode = 2'b10;
        tick();
        check("skip_q1", 32'(a_q), 32'h1);
        check("skip_rco1", 32'(a_rco), 32'h0);
        check("skip_sq1", 32'(s_q), 32'h1);
        check("skip_tc1", 32'(a_tc), 32'h1);
        tick();
        check("skip_wrap_q", 32'(a_q), 32'hE);
        check("skip_wrap_rco", 32'(a_rco), 32'h1);
        check("sat_q0", 32'(s_q), 32'h0);
        check("sat_rco0", 32'(s_rco), 32'h1);
        tick();
        check("skip_qB", 32'(a_q), 32'hB);
        check("skip_rcoB", 32'(a_rco), 32'h0);
        check("sat_hold_q", 32'(s_q), 32'h0);
        check("sat_rco_rep", 32'(s_rco), 32'h1);

        // 4. enable=0 ignores load; cin=0 holds a counting mode
        a_mode = 2'b11; a_d = 4'h5;
        tick();
        check("ld5_q", 32'(a_q), 32'h5);
        a_en = 1'b0; a_d = 4'h9;
        tick();
        check("hold_q", 32'(a_q), 32'h5);
        check("hold_load", 32'(a_load), 32'h0);
        a_en = 1'b1; a_cin = 1'b0; a_mode = 2'b01;
        tick();
        check("cin0_q", 32'(a_q), 32'h5);
        check("cin0_rco", 32'(a_rco), 32'h0);
        check("cin0_tc", 32'(a_tc), 32'h0);

        // 6a. reset wins on the wrap edge
        a_cin = 1'b1; a_mode = 2'b11; a_d = 4'hF;
        tick();
        a_mode = 2'b00; a_rst = 1'b1;
        tick();
        check("rstwin_q", 32'(a_q), 32'h0);
        check("rstwin_rco", 32'(a_rco), 32'h0);

        // down from 0: wrap to F vs clamp at 0
        a_rst = 1'b0; a_mode = 2'b01;
        tick();
        check("dn_wrap_q", 32'(a_q), 32'hF);
        check("dn_wrap_rco", 32'(a_rco), 32'h1);
        check("dn_sat_q", 32'(s_q), 32'h0);
        check("dn_sat_rco", 32'(s_rco), 32'h1);

        // 5. cascade
        c_rst = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        check("casc16_hi", 32'(hi_q), 32'h1);
        check("casc16_lo", 32'(lo_q), 32'h0);
        for (int i = 0; i < 240; i++) tick();
        check("casc256_hi", 32'(hi_q), 32'h0);
        check("casc256_lo", 32'(lo_q), 32'h0);
        check("casc256_rco", 32'(hi_rco), 32'h1);

        // 6b. 32-bit wrap
        w_rst = 1'b0; w_mode = 2'b11; w_d = 32'hFFFF_FFFF;
        tick();
        check("w_ld_q", w_q, 32'hFFFF_FFFF);
        w_mode = 2'b00; #1;
        check("w_tc", 32'(w_tc), 32'h1);
        tick();
        check("w_wrap_q", w_q, 32'h0);
        check("w_wrap_rco", 32'(w_rco), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
